// File: rtl/jac_pkg.sv
// Shared definitions for the Jac1-8 core: opcodes, status bits, instruction fields, FSM states.
package jac_pkg;

  // Opcodes
  localparam logic [4:0] OpNop  = 5'h00;
  localparam logic [4:0] OpAdd  = 5'h01;
  localparam logic [4:0] OpSub  = 5'h02;
  localparam logic [4:0] OpAnd  = 5'h03;
  localparam logic [4:0] OpOr   = 5'h04;
  localparam logic [4:0] OpNot  = 5'h05;
  localparam logic [4:0] OpXor  = 5'h06;
  localparam logic [4:0] OpShl  = 5'h07;
  localparam logic [4:0] OpShr  = 5'h08;
  localparam logic [4:0] OpVal  = 5'h09;
  localparam logic [4:0] OpGoto = 5'h10;
  localparam logic [4:0] OpIfz  = 5'h11;
  localparam logic [4:0] OpIfnz = 5'h12;
  localparam logic [4:0] OpIfeq = 5'h13;
  localparam logic [4:0] OpIfst = 5'h14;
  localparam logic [4:0] OpIfgt = 5'h15;

  // Reserved opcode ranges (executed as NOP, flagged as illegal)
  localparam logic [4:0] OpRsvdLoFirst = 5'h0A;
  localparam logic [4:0] OpRsvdLoLast  = 5'h0F;
  localparam logic [4:0] OpRsvdHiFirst = 5'h16;
  localparam logic [4:0] OpRsvdHiLast  = 5'h1F;

  // ALU status bit indices
  localparam int unsigned StatusCarry     = 0;
  localparam int unsigned StatusUnderflow = 1;
  localparam int unsigned StatusZero      = 2;

  // Instruction field positions
  localparam int unsigned OpcodeMsb = 17;
  localparam int unsigned OpcodeLsb = 13;
  localparam int unsigned RaMsb     = 12;
  localparam int unsigned RaLsb     = 11;
  localparam int unsigned RbMsb     = 10;
  localparam int unsigned RbLsb     = 9;
  localparam int unsigned RsvdBit   = 8;
  localparam int unsigned ParamMsb  = 7;
  localparam int unsigned ParamLsb  = 0;

  // Sequencer states
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFetch = 2'd1,
    StExec  = 2'd2
  } state_e;

  function automatic logic is_reserved(input logic [4:0] op);
    return ((op >= OpRsvdLoFirst) && (op <= OpRsvdLoLast)) ||
           ((op >= OpRsvdHiFirst) && (op <= OpRsvdHiLast));
  endfunction

  function automatic logic is_alu_op(input logic [4:0] op);
    return (op >= OpAdd) && (op <= OpShr);
  endfunction

endpackage

// File: rtl/jac_regfile.sv
// Register file: NumRegs x DataWidth, one synchronous write port, three combinational reads.
module jac_regfile #(
  parameter int unsigned NumRegs   = 4,
  parameter int unsigned DataWidth = 8,
  localparam int unsigned SelWidth = (NumRegs > 1) ? $clog2(NumRegs) : 1
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 we,
  input  logic [SelWidth-1:0]  waddr,
  input  logic [DataWidth-1:0] wdata,
  input  logic [SelWidth-1:0]  raddr_a,
  output logic [DataWidth-1:0] rdata_a,
  input  logic [SelWidth-1:0]  raddr_b,
  output logic [DataWidth-1:0] rdata_b,
  input  logic [SelWidth-1:0]  dbg_sel,
  output logic [DataWidth-1:0] dbg_data
);

  logic [DataWidth-1:0] regs_q [NumRegs];
  logic [DataWidth-1:0] regs_d [NumRegs];

  // Next-state: single write port
  always_comb begin
    regs_d = regs_q;
    if (we) begin
      regs_d[waddr] = wdata;
    end
  end

  // Storage with asynchronous clear
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NumRegs; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  assign rdata_a  = regs_q[raddr_a];
  assign rdata_b  = regs_q[raddr_b];
  assign dbg_data = regs_q[dbg_sel];

endmodule

// File: rtl/jac_control_unit.sv
// Jac1-8 instruction sequencer: fetch, decode, drive ALU, write back, resolve branches.
module jac_control_unit
  import jac_pkg::*;
#(
  parameter int unsigned DataWidth     = 8,
  parameter int unsigned AddrWidth     = 8,
  parameter int unsigned InstrWidth    = 18,
  parameter int unsigned NumRegs       = 4,
  parameter int unsigned NumStatusBits = 3
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     run,
  output logic                     imem_req,
  output logic [AddrWidth-1:0]     imem_addr,
  input  logic                     imem_valid,
  input  logic [InstrWidth-1:0]    imem_data,
  output logic [4:0]               alu_opcode,
  output logic [DataWidth-1:0]     alu_operand1,
  output logic [DataWidth-1:0]     alu_operand2,
  output logic [DataWidth-1:0]     alu_param,
  input  logic [DataWidth-1:0]     alu_result,
  input  logic [NumStatusBits-1:0] alu_status,
  output logic [AddrWidth-1:0]     pc,
  output logic [NumStatusBits-1:0] flags,
  output logic                     busy,
  output logic                     illegal,
  input  logic [1:0]               dbg_sel,
  output logic [DataWidth-1:0]     dbg_data
);

  state_e                   state_q, state_d;
  logic [AddrWidth-1:0]     pc_q, pc_d;
  logic [NumStatusBits-1:0] flags_q, flags_d;
  logic [InstrWidth-1:0]    ir_q, ir_d;
  logic                     illegal_q, illegal_d;

  logic                     rf_we;
  logic [DataWidth-1:0]     rf_wdata;
  logic [DataWidth-1:0]     rdata_a, rdata_b;

  // Decoded instruction fields
  logic [4:0]               ir_op;
  logic [1:0]               ir_ra, ir_rb;
  logic [7:0]               ir_param;
  logic [AddrWidth-1:0]     target;
  logic                     in_exec;

  assign ir_op    = ir_q[OpcodeMsb:OpcodeLsb];
  assign ir_ra    = ir_q[RaMsb:RaLsb];
  assign ir_rb    = ir_q[RbMsb:RbLsb];
  assign ir_param = ir_q[ParamMsb:ParamLsb];
  assign target   = AddrWidth'(ir_param);
  assign in_exec  = (state_q == StExec);

  // Bit 8 of the instruction word carries no meaning.
  logic unused_rsvd;
  assign unused_rsvd = ir_q[RsvdBit];

  jac_regfile #(
    .NumRegs  (NumRegs),
    .DataWidth(DataWidth)
  ) u_regfile (
    .clock   (clock),
    .reset_n (reset_n),
    .we      (rf_we),
    .waddr   (ir_ra),
    .wdata   (rf_wdata),
    .raddr_a (ir_ra),
    .rdata_a (rdata_a),
    .raddr_b (ir_rb),
    .rdata_b (rdata_b),
    .dbg_sel (dbg_sel),
    .dbg_data(dbg_data)
  );

  // Next-state, writeback and program-flow resolution
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    flags_d   = flags_q;
    ir_d      = ir_q;
    illegal_d = 1'b0;
    rf_we     = 1'b0;
    rf_wdata  = alu_result;

    unique case (state_q)
      StIdle: begin
        if (run) begin
          state_d = StFetch;
        end
      end
      StFetch: begin
        if (imem_valid) begin
          ir_d    = imem_data;
          state_d = StExec;
        end
      end
      StExec: begin
        state_d = run ? StFetch : StIdle;
        pc_d    = pc_q + AddrWidth'(1);
        if (is_alu_op(ir_op)) begin
          rf_we   = 1'b1;
          flags_d = alu_status;
        end else begin
          case (ir_op)
            OpVal: begin
              rf_we    = 1'b1;
              rf_wdata = DataWidth'(ir_param);
            end
            OpGoto: pc_d = target;
            OpIfz:  if (flags_q[StatusZero])  pc_d = target;
            OpIfnz: if (!flags_q[StatusZero]) pc_d = target;
            OpIfeq: if (rdata_a == rdata_b)   pc_d = target;
            OpIfst: if (rdata_a <  rdata_b)   pc_d = target;
            OpIfgt: if (rdata_a >  rdata_b)   pc_d = target;
            default: begin
              // NOP falls through here too; only reserved codes raise illegal.
              illegal_d = is_reserved(ir_op);
            end
          endcase
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with asynchronous clear
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      pc_q      <= '0;
      flags_q   <= '0;
      ir_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      flags_q   <= flags_d;
      ir_q      <= ir_d;
      illegal_q <= illegal_d;
    end
  end

  // Output drive: ALU inputs are live only during EXEC
  always_comb begin
    alu_opcode   = in_exec ? ir_op : OpNop;
    alu_operand1 = in_exec ? rdata_a : '0;
    alu_operand2 = in_exec ? rdata_b : '0;
    alu_param    = in_exec ? DataWidth'(ir_param) : '0;
  end

  assign imem_req  = (state_q == StFetch);
  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign flags     = flags_q;
  assign busy      = (state_q != StIdle);
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_jac_control_unit.sv
// Self-checking bench for jac_control_unit with a behavioural ALU and program memory.
module tb_jac_control_unit;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        run;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_valid;
  logic [17:0] imem_data;
  logic [4:0]  alu_opcode;
  logic [7:0]  alu_operand1, alu_operand2, alu_param;
  logic [7:0]  alu_result;
  logic [2:0]  alu_status;
  logic [7:0]  pc;
  logic [2:0]  flags;
  logic        busy;
  logic        illegal;
  logic [1:0]  dbg_sel;
  logic [7:0]  dbg_data;

  logic [17:0] mem [256];
  logic        stall;
  logic [7:0]  exp_addr_q [$];
  int          n_checks = 0;
  int          n_pass = 0;
  int          fetch_cnt = 0;
  int          illegal_cnt = 0;

  always #5 clock = ~clock;

  jac_control_unit dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .run         (run),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_valid  (imem_valid),
    .imem_data   (imem_data),
    .alu_opcode  (alu_opcode),
    .alu_operand1(alu_operand1),
    .alu_operand2(alu_operand2),
    .alu_param   (alu_param),
    .alu_result  (alu_result),
    .alu_status  (alu_status),
    .pc          (pc),
    .flags       (flags),
    .busy        (busy),
    .illegal     (illegal),
    .dbg_sel     (dbg_sel),
    .dbg_data    (dbg_data)
  );

  assign imem_valid = imem_req && !stall;
  assign imem_data  = mem[imem_addr];

  // Behavioural ALU: status = {zero, underflow, carry}
  always_comb begin
    logic [8:0] wide;
    wide       = 9'h0;
    alu_result = 8'h00;
    alu_status = 3'b000;
    case (alu_opcode)
      5'h01: wide = {1'b0, alu_operand1} + {1'b0, alu_operand2};
      5'h02: wide = {(alu_operand1 < alu_operand2), alu_operand1 - alu_operand2};
      5'h03: wide = {1'b0, alu_operand1 & alu_operand2};
      5'h04: wide = {1'b0, alu_operand1 | alu_operand2};
      5'h05: wide = {1'b0, ~alu_operand1};
      5'h06: wide = {1'b0, alu_operand1 ^ alu_operand2};
      5'h07: wide = {alu_operand1[7], alu_operand1[6:0], 1'b0};
      5'h08: wide = {alu_operand1[0], 1'b0, alu_operand1[7:1]};
      default: wide = 9'h0;
    endcase
    if (alu_opcode >= 5'h01 && alu_opcode <= 5'h08) begin
      alu_result    = wide[7:0];
      alu_status[2] = (wide[7:0] == 8'h00);
      if (alu_opcode == 5'h02) alu_status[1] = wide[8];
      else                     alu_status[0] = wide[8];
    end
  end

  // Scoreboard: each completed fetch must match the next expected address
  always @(negedge clock) begin
    if (reset_n && imem_req && imem_valid) begin
      fetch_cnt++;
      n_checks++;
      if (exp_addr_q.size() == 0) begin
        $display("FAIL fetch_addr: unexpected fetch at 0x%02h, none expected", imem_addr);
      end else begin
        logic [7:0] exp;
        exp = exp_addr_q.pop_front();
        if (imem_addr !== exp) $display("FAIL fetch_addr: got 0x%02h want 0x%02h", imem_addr, exp);
        else n_pass++;
      end
    end
    if (illegal === 1'b1) illegal_cnt++;
  end

  function automatic logic [17:0] enc(input logic [4:0] op, input logic [1:0] ra,
                                      input logic [1:0] rb, input logic [7:0] p);
    return {op, ra, rb, 1'b0, p};
  endfunction

  task automatic do_reset();
    reset_n = 1'b0;
    run     = 1'b0;
    stall   = 1'b0;
    dbg_sel = 2'd0;
    n_checks++;
    if (exp_addr_q.size() != 0) $display("FAIL sb_drain: %0d fetches left, want 0", exp_addr_q.size());
    else n_pass++;
    exp_addr_q.delete();
    for (int i = 0; i < 256; i++) mem[i] = 18'h0;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
  endtask

  // Run until n instructions are fetched, drop run in the last EXEC, wait for IDLE.
  task automatic run_instrs(input int n);
    int start;
    bit done;
    start = fetch_cnt;
    done  = 1'b0;
    run   = 1'b1;
    for (int c = 0; c < 200 && !done; c++) begin
      @(posedge clock); #1;
      if (fetch_cnt >= start + n) done = 1'b1;
    end
    run = 1'b0;
    for (int c = 0; c < 10 && busy; c++) begin
      @(posedge clock); #1;
    end
    n_checks++;
    if (!done || busy) $display("FAIL run_timeout: done=%0b busy=%0b want done=1 busy=0", done, busy);
    else n_pass++;
  endtask

  task automatic read_reg(input logic [1:0] sel, output logic [7:0] val);
    dbg_sel = sel;
    #1 val = dbg_data;
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      @(posedge clock); #1;
      n_checks++;
      if ({pc, flags, busy, imem_req, illegal, alu_opcode} !== '0)
        $display("FAIL reset_idle: pc=%h flags=%b busy=%b req=%b ill=%b op=%h want all 0",
                 pc, flags, busy, imem_req, illegal, alu_opcode);
      else n_pass++;
    end
  endtask

  task automatic test_load_add();
    logic [7:0] v;
    do_reset();
    mem[0] = enc(5'h09, 2'd0, 2'd0, 8'h05);
    mem[1] = enc(5'h09, 2'd1, 2'd0, 8'hFC);
    mem[2] = enc(5'h01, 2'd0, 2'd1, 8'h00);
    exp_addr_q.push_back(8'h00);
    exp_addr_q.push_back(8'h01);
    exp_addr_q.push_back(8'h02);
    run = 1'b1;
    repeat (6) @(posedge clock);
    #1 run = 1'b0;
    @(posedge clock); #1;
    n_checks++;
    if (pc !== 8'h03 || busy !== 1'b0) $display("FAIL add_timing: pc=%h busy=%b want 03/0", pc, busy);
    else n_pass++;
    n_checks++;
    if (flags !== 3'b001) $display("FAIL add_flags: got %b want 001", flags);
    else n_pass++;
    read_reg(2'd0, v);
    n_checks++;
    if (v !== 8'h01) $display("FAIL add_r0: got %h want 01", v);
    else n_pass++;
    read_reg(2'd1, v);
    n_checks++;
    if (v !== 8'hFC) $display("FAIL add_r1: got %h want fc", v);
    else n_pass++;
  endtask

  task automatic test_zero_branch();
    logic [7:0] v;
    logic [7:0] want;
    for (int k = 0; k < 2; k++) begin
      do_reset();
      mem[0] = enc(5'h09, 2'd2, 2'd0, 8'h07);
      mem[1] = enc(5'h02, 2'd2, 2'd2, 8'h00);
      mem[2] = enc((k == 0) ? 5'h11 : 5'h12, 2'd0, 2'd0, 8'h10);
      want   = (k == 0) ? 8'h10 : 8'h03;
      for (int a = 0; a < 3; a++) exp_addr_q.push_back(8'(a));
      run_instrs(3);
      read_reg(2'd2, v);
      n_checks++;
      if (v !== 8'h00) $display("FAIL zero_r2[%0d]: got %h want 00", k, v);
      else n_pass++;
      n_checks++;
      if (flags !== 3'b100) $display("FAIL zero_flags[%0d]: got %b want 100", k, flags);
      else n_pass++;
      n_checks++;
      if (imem_addr !== want) $display("FAIL zero_branch[%0d]: got %h want %h", k, imem_addr, want);
      else n_pass++;
    end
  endtask

  task automatic test_compare();
    do_reset();
    mem[8'h00] = enc(5'h09, 2'd0, 2'd0, 8'h03);
    mem[8'h01] = enc(5'h09, 2'd1, 2'd0, 8'h09);
    mem[8'h02] = enc(5'h14, 2'd0, 2'd1, 8'h40);
    mem[8'h40] = enc(5'h15, 2'd0, 2'd1, 8'h50);
    mem[8'h41] = enc(5'h13, 2'd1, 2'd1, 8'h22);
    exp_addr_q.push_back(8'h00);
    exp_addr_q.push_back(8'h01);
    exp_addr_q.push_back(8'h02);
    exp_addr_q.push_back(8'h40);
    exp_addr_q.push_back(8'h41);
    run_instrs(5);
    n_checks++;
    if (pc !== 8'h22) $display("FAIL cmp_pc: got %h want 22", pc);
    else n_pass++;
    n_checks++;
    if (flags !== 3'b000) $display("FAIL cmp_flags: got %b want 000", flags);
    else n_pass++;
  endtask

  task automatic test_stall();
    logic [7:0] v;
    do_reset();
    mem[0] = enc(5'h09, 2'd3, 2'd0, 8'hAA);
    exp_addr_q.push_back(8'h00);
    stall = 1'b1;
    run   = 1'b1;
    @(posedge clock); #1;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (imem_req !== 1'b1 || imem_addr !== 8'h00 || busy !== 1'b1 || alu_opcode !== 5'h00)
        $display("FAIL stall_hold[%0d]: req=%b addr=%h busy=%b op=%h want 1/00/1/00",
                 i, imem_req, imem_addr, busy, alu_opcode);
      else n_pass++;
      @(posedge clock); #1;
    end
    stall = 1'b0;
    @(posedge clock); #1;
    run = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || alu_opcode !== 5'h09 || alu_param !== 8'hAA)
      $display("FAIL stall_exec: busy=%b op=%h param=%h want 1/09/aa", busy, alu_opcode, alu_param);
    else n_pass++;
    @(posedge clock); #1;
    read_reg(2'd3, v);
    n_checks++;
    if (busy !== 1'b0 || imem_req !== 1'b0 || pc !== 8'h01 || v !== 8'hAA)
      $display("FAIL stall_stop: busy=%b req=%b pc=%h r3=%h want 0/0/01/aa", busy, imem_req, pc, v);
    else n_pass++;
  endtask

  task automatic test_wrap_illegal();
    logic [7:0] v;
    int ill0;
    do_reset();
    mem[8'h00] = enc(5'h10, 2'd0, 2'd0, 8'hFF);
    mem[8'hFF] = enc(5'h00, 2'd0, 2'd0, 8'h00);
    exp_addr_q.push_back(8'h00);
    exp_addr_q.push_back(8'hFF);
    run_instrs(2);
    n_checks++;
    if (pc !== 8'h00) $display("FAIL pc_wrap: got %h want 00", pc);
    else n_pass++;

    do_reset();
    mem[0] = enc(5'h09, 2'd0, 2'd0, 8'h80);
    mem[1] = enc(5'h01, 2'd0, 2'd0, 8'h00);
    mem[2] = enc(5'h0A, 2'd0, 2'd0, 8'h5A);
    for (int a = 0; a < 3; a++) exp_addr_q.push_back(8'(a));
    ill0 = illegal_cnt;
    run_instrs(3);
    repeat (2) @(posedge clock);
    #1;
    n_checks++;
    if (illegal_cnt - ill0 != 1) $display("FAIL illegal_pulse: %0d cycles want 1", illegal_cnt - ill0);
    else n_pass++;
    read_reg(2'd0, v);
    n_checks++;
    if (v !== 8'h00 || flags !== 3'b101 || pc !== 8'h03)
      $display("FAIL illegal_state: r0=%h flags=%b pc=%h want 00/101/03", v, flags, pc);
    else n_pass++;
  endtask

  task automatic test_reset_mid_exec();
    logic [7:0] v;
    do_reset();
    mem[0] = enc(5'h09, 2'd1, 2'd0, 8'h33);
    exp_addr_q.push_back(8'h00);
    run = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    n_checks++;
    if (busy !== 1'b1 || alu_opcode !== 5'h09 || alu_param !== 8'h33)
      $display("FAIL mid_exec_pre: busy=%b op=%h param=%h want 1/09/33", busy, alu_opcode, alu_param);
    else n_pass++;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({imem_req, busy, illegal, alu_opcode, alu_operand1, alu_operand2, alu_param, pc, flags} !== '0)
      $display("FAIL mid_exec_reset: req=%b busy=%b op=%h p=%h pc=%h flags=%b want all 0",
               imem_req, busy, alu_opcode, alu_param, pc, flags);
    else n_pass++;
    @(posedge clock); #1;
    read_reg(2'd1, v);
    n_checks++;
    if (v !== 8'h00) $display("FAIL mid_exec_wb: r1=%h want 00", v);
    else n_pass++;
    run = 1'b0;
    reset_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_load_add();
    test_zero_branch();
    test_compare();
    test_stall();
    test_wrap_illegal();
    test_reset_mid_exec();
    do_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
